// File: rtl/calcore_pkg.sv
// Shared CalCore definitions: instruction width, legal opcode/funct3 pairs,
// fetch FSM state encoding and the legality helper used by fetch and decode.
package calcore_pkg;

    localparam int INSTR_W = 32;

    // Custom opcode spaces: "set" group and "calc" group
    localparam logic [6:0] OPC_SET  = 7'b0001011;
    localparam logic [6:0] OPC_CALC = 7'b0101011;

    localparam logic [6:0] OP_SET_HEIGHT  = OPC_SET;
    localparam logic [2:0] F3_SET_HEIGHT  = 3'd0;
    localparam logic [6:0] OP_SET_WEIGHT  = OPC_SET;
    localparam logic [2:0] F3_SET_WEIGHT  = 3'd1;
    localparam logic [6:0] OP_CALC_BMI    = OPC_CALC;
    localparam logic [2:0] F3_CALC_BMI    = 3'd0;
    localparam logic [6:0] OP_CALC_BMR    = OPC_CALC;
    localparam logic [2:0] F3_CALC_BMR    = 3'd1;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_RUN   = 2'd1,
        ST_DRAIN = 2'd2,
        ST_DONE  = 2'd3
    } fetch_state_t;

    // True when opcode [6:0] and funct3 [14:12] name one of the four instructions
    function automatic logic is_legal_instr(input logic [INSTR_W-1:0] w);
        logic [6:0] op;
        logic [2:0] f3;
        op = w[6:0];
        f3 = w[14:12];
        return ((op == OP_SET_HEIGHT) && (f3 == F3_SET_HEIGHT)) ||
               ((op == OP_SET_WEIGHT) && (f3 == F3_SET_WEIGHT)) ||
               ((op == OP_CALC_BMI)   && (f3 == F3_CALC_BMI))   ||
               ((op == OP_CALC_BMR)   && (f3 == F3_CALC_BMR));
    endfunction

endpackage

// File: rtl/calcore_fetch_if.sv
// Instruction delivery bus from fetch to decode: valid/ready handshake.
interface calcore_fetch_if;
    import calcore_pkg::*;

    logic [INSTR_W-1:0] instr;
    logic               instr_valid;
    logic               instr_ready;

    modport master (output instr, output instr_valid, input instr_ready);
    modport slave  (input instr, input instr_valid, output instr_ready);
endinterface

// File: rtl/calcore_fetch_fifo.sv
// Small synchronous FIFO with a registered head word, occupancy count and
// simultaneous push/pop at any fill level (including full).
module calcore_fetch_fifo #(
    parameter  int DEPTH = 4,
    parameter  int WIDTH = 32,
    localparam int PTR_W = $clog2(DEPTH),
    localparam int CNT_W = PTR_W + 1
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             i_push,
    input  logic [WIDTH-1:0] i_push_data,
    input  logic             i_pop,
    output logic [WIDTH-1:0] o_head,
    output logic             o_valid,
    output logic [CNT_W-1:0] o_count
);

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [PTR_W-1:0] r_wr_ptr;
    logic [PTR_W-1:0] r_rd_ptr;
    logic [CNT_W-1:0] r_count;
    logic [WIDTH-1:0] r_head;

    logic             w_pop;
    logic [PTR_W-1:0] w_rd_ptr_next;
    logic [CNT_W-1:0] w_remain;

    assign w_pop         = i_pop & (r_count != '0);
    assign w_rd_ptr_next = r_rd_ptr + PTR_W'(w_pop);
    // Entries still held after this cycle's pop, before this cycle's push
    assign w_remain      = r_count - CNT_W'(w_pop);

    // Storage array write port; contents need no reset
    always_ff @(posedge clk) begin
        if (i_push) begin
            r_mem[r_wr_ptr] <= i_push_data;
        end
    end

    // Pointers, count and the registered head word
    always_ff @(posedge clk) begin
        if (reset) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
            r_head   <= '0;
        end else begin
            if (i_push) begin
                r_wr_ptr <= r_wr_ptr + PTR_W'(1);
            end
            r_rd_ptr <= w_rd_ptr_next;
            r_count  <= w_remain + CNT_W'(i_push);
            // Next head comes from storage if anything is left, otherwise a
            // push into an effectively empty FIFO bypasses straight to the head.
            if (w_remain != '0) begin
                r_head <= r_mem[w_rd_ptr_next];
            end else if (i_push) begin
                r_head <= i_push_data;
            end
        end
    end

    assign o_head  = r_head;
    assign o_valid = (r_count != '0);
    assign o_count = r_count;

endmodule

// File: rtl/calcore_fetch.sv
// CalCore instruction fetch: host-loadable program RAM, PC-driven fetch FSM
// with one-cycle synchronous read, and a credit-limited output FIFO.
// Optional build macro OPCODE_FILTER_EN drops words that are not one of the
// four legal instructions and counts them in illegal_count.
module calcore_fetch
    import calcore_pkg::*;
#(
    parameter int PROG_DEPTH = 64,
    parameter int ADDR_W     = $clog2(PROG_DEPTH),
    parameter int FIFO_DEPTH = 4
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               load_we,
    input  logic [ADDR_W-1:0]  load_addr,
    input  logic [INSTR_W-1:0] load_data,
    input  logic [ADDR_W:0]    prog_len,
    input  logic               start,
    input  logic               halt_req,
    calcore_fetch_if.master    fetch_bus,
    output logic [ADDR_W-1:0]  pc,
    output logic               busy,
    output logic               done,
    output logic [15:0]        instr_count,
    output logic [7:0]         illegal_count
);

    localparam int CNT_W = $clog2(FIFO_DEPTH) + 1;

    fetch_state_t       r_state;
    fetch_state_t       w_state_next;
    logic [ADDR_W:0]    r_pc;
    logic [ADDR_W:0]    r_len;
    logic [ADDR_W:0]    w_len_clamped;
    logic               r_rd_valid;
    logic [INSTR_W-1:0] r_rd_data;
    logic [INSTR_W-1:0] r_prog_mem [PROG_DEPTH];
    logic [15:0]        r_instr_count;
    logic [7:0]         r_illegal_count;

    logic               w_issue;
    logic               w_start_take;
    logic               w_credit;
    logic               w_load_ok;
    logic               w_legal;
    logic               w_push;
    logic               w_drop;
    logic               w_handshake;
    logic [INSTR_W-1:0] w_fifo_head;
    logic               w_fifo_valid;
    logic [CNT_W-1:0]   w_fifo_count;

    assign w_len_clamped = (prog_len > (ADDR_W+1)'(PROG_DEPTH)) ? (ADDR_W+1)'(PROG_DEPTH) : prog_len;

    // Words in the FIFO plus the read in flight must leave room for one more
    assign w_credit = ({1'b0, w_fifo_count} + (CNT_W+1)'(r_rd_valid)) < (CNT_W+1)'(FIFO_DEPTH);

    // The active program is protected while a run is in progress
    assign w_load_ok = load_we & ((r_state == ST_IDLE) | (r_state == ST_DONE));

    // Next-state and issue decision; halt wins over an issue in the same cycle
    always_comb begin
        w_state_next = r_state;
        w_issue      = 1'b0;
        w_start_take = 1'b0;
        case (r_state)
            ST_IDLE, ST_DONE: begin
                if (start) begin
                    w_start_take = 1'b1;
                    w_state_next = (w_len_clamped != '0) ? ST_RUN : ST_DONE;
                end
            end
            ST_RUN: begin
                if (halt_req) begin
                    w_state_next = ST_DRAIN;
                end else if (w_credit && (r_pc < r_len)) begin
                    w_issue = 1'b1;
                    if ((r_pc + (ADDR_W+1)'(1)) == r_len) begin
                        w_state_next = ST_DRAIN;
                    end
                end
            end
            ST_DRAIN: begin
                if ((w_fifo_count == '0) && !r_rd_valid) begin
                    w_state_next = ST_DONE;
                end
            end
            default: w_state_next = ST_IDLE;
        endcase
    end

    // Program RAM: host write port and registered fetch read port
    always_ff @(posedge clk) begin
        if (w_load_ok) begin
            r_prog_mem[load_addr] <= load_data;
        end
        if (w_issue) begin
            r_rd_data <= r_prog_mem[r_pc[ADDR_W-1:0]];
        end
    end

`ifdef OPCODE_FILTER_EN
    assign w_legal = is_legal_instr(r_rd_data);
`else
    assign w_legal = 1'b1;
`endif

    // A returned read always releases its credit, whether pushed or dropped
    assign w_push      = r_rd_valid & w_legal;
    assign w_drop      = r_rd_valid & ~w_legal;
    assign w_handshake = w_fifo_valid & fetch_bus.instr_ready;

    // FSM state, PC, in-flight flag and run counters
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state         <= ST_IDLE;
            r_pc            <= '0;
            r_len           <= '0;
            r_rd_valid      <= 1'b0;
            r_instr_count   <= '0;
            r_illegal_count <= '0;
        end else begin
            r_state    <= w_state_next;
            r_rd_valid <= w_issue;
            if (w_start_take) begin
                r_len           <= w_len_clamped;
                r_pc            <= '0;
                r_instr_count   <= '0;
                r_illegal_count <= '0;
            end else begin
                if (w_issue) begin
                    r_pc <= r_pc + (ADDR_W+1)'(1);
                end
                if (w_handshake && (r_instr_count != 16'hFFFF)) begin
                    r_instr_count <= r_instr_count + 16'd1;
                end
                if (w_drop && (r_illegal_count != 8'hFF)) begin
                    r_illegal_count <= r_illegal_count + 8'd1;
                end
            end
        end
    end

    calcore_fetch_fifo #(
        .DEPTH (FIFO_DEPTH),
        .WIDTH (INSTR_W)
    ) u_fifo (
        .clk         (clk),
        .reset       (reset),
        .i_push      (w_push),
        .i_push_data (r_rd_data),
        .i_pop       (fetch_bus.instr_ready),
        .o_head      (w_fifo_head),
        .o_valid     (w_fifo_valid),
        .o_count     (w_fifo_count)
    );

    assign fetch_bus.instr       = w_fifo_head;
    assign fetch_bus.instr_valid = w_fifo_valid;

    // pc reports the low address bits; at a full-depth length it reads as 0
    assign pc            = r_pc[ADDR_W-1:0];
    assign busy          = (r_state == ST_RUN) | (r_state == ST_DRAIN);
    assign done          = (r_state == ST_DONE);
    assign instr_count   = r_instr_count;
    assign illegal_count = r_illegal_count;

endmodule

// File: tb/tb_calcore_fetch.sv
// Self-checking bench for calcore_fetch: scoreboard queue of expected words,
// table of run configurations, and hand-written multi-cycle corner cases.
`timescale 1ns/1ps
module tb_calcore_fetch;
    import calcore_pkg::*;

    localparam int PROG_DEPTH = 64;
    localparam int ADDR_W     = 6;
    localparam int FIFO_DEPTH = 4;

    logic              clk = 1'b0;
    logic              reset;
    logic              load_we;
    logic [ADDR_W-1:0] load_addr;
    logic [31:0]       load_data;
    logic [ADDR_W:0]   prog_len;
    logic              start;
    logic              halt_req;
    logic [ADDR_W-1:0] pc;
    logic              busy;
    logic              done;
    logic [15:0]       instr_count;
    logic [7:0]        illegal_count;

    calcore_fetch_if fetch_bus();

    calcore_fetch #(
        .PROG_DEPTH (PROG_DEPTH),
        .ADDR_W     (ADDR_W),
        .FIFO_DEPTH (FIFO_DEPTH)
    ) dut (
        .clk           (clk),
        .reset         (reset),
        .load_we       (load_we),
        .load_addr     (load_addr),
        .load_data     (load_data),
        .prog_len      (prog_len),
        .start         (start),
        .halt_req      (halt_req),
        .fetch_bus     (fetch_bus),
        .pc            (pc),
        .busy          (busy),
        .done          (done),
        .instr_count   (instr_count),
        .illegal_count (illegal_count)
    );

    always #5 clk = ~clk;

    logic [31:0] exp_q[$];
    logic [31:0] tb_mem [PROG_DEPTH];
    int errors = 0;
    int checks = 0;
    int hs_count = 0;
    int exp_cnt = 0;
    int exp_ill = 0;
    bit valid_seen = 1'b0;

    typedef struct {
        int    len;
        bit    rnd;
        string name;
        int    exp_pc;
    } vec_t;
    vec_t vecs[5];

    function automatic logic [31:0] mk_word(input int i);
        return {17'(i), F3_SET_HEIGHT, 5'(i), OP_SET_HEIGHT};
    endfunction

    function automatic bit tb_legal(input logic [31:0] w);
        return (w[6:0] == OP_SET_HEIGHT && w[14:12] == F3_SET_HEIGHT) ||
               (w[6:0] == OP_SET_WEIGHT && w[14:12] == F3_SET_WEIGHT) ||
               (w[6:0] == OP_CALC_BMI   && w[14:12] == F3_CALC_BMI)   ||
               (w[6:0] == OP_CALC_BMR   && w[14:12] == F3_CALC_BMR);
    endfunction

    // Scoreboard: every completed handshake pops and compares one expected word
    always @(negedge clk) begin
        logic [31:0] e;
        if (!reset && fetch_bus.instr_valid) valid_seen = 1'b1;
        if (!reset && fetch_bus.instr_valid && fetch_bus.instr_ready) begin
            checks++;
            hs_count++;
            if (exp_q.size() == 0) begin
                errors++;
                $display("FAIL sb_extra: got instr=%08h, required no word", fetch_bus.instr);
            end else begin
                e = exp_q.pop_front();
                $display("xfer %0d instr=%08h expected=%08h", hs_count, fetch_bus.instr, e);
                if (fetch_bus.instr !== e) begin
                    errors++;
                    $display("FAIL sb_word: got %08h, required %08h", fetch_bus.instr, e);
                end
            end
        end
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got %08h, required %08h", name, act, req);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic load_word(input int addr, input logic [31:0] data, input bit track);
        load_we   = 1'b1;
        load_addr = ADDR_W'(addr);
        load_data = data;
        tick();
        load_we   = 1'b0;
        if (track) tb_mem[addr] = data;
    endtask

    // Queue the expected delivery for a run and pulse start for one cycle
    task automatic start_run(input int len);
        int l;
        l = (len > PROG_DEPTH) ? PROG_DEPTH : len;
        exp_cnt  = 0;
        exp_ill  = 0;
        hs_count = 0;
        for (int i = 0; i < l; i++) begin
`ifdef OPCODE_FILTER_EN
            if (tb_legal(tb_mem[i])) begin
                exp_q.push_back(tb_mem[i]);
                exp_cnt++;
            end else begin
                exp_ill++;
            end
`else
            exp_q.push_back(tb_mem[i]);
            exp_cnt++;
`endif
        end
        prog_len = (ADDR_W+1)'(len);
        start    = 1'b1;
        tick();
        start    = 1'b0;
    endtask

    task automatic finish_run(input bit rnd, input string name);
        int n;
        n = 0;
        while (!done && n < 3000) begin
            fetch_bus.instr_ready = rnd ? ($urandom_range(0, 1) == 1) : 1'b1;
            tick();
            n++;
        end
        fetch_bus.instr_ready = 1'b1;
        check({name, "_done"}, 32'(done), 32'd1);
        check({name, "_left"}, 32'(exp_q.size()), 32'd0);
        check({name, "_icount"}, 32'(instr_count), 32'(exp_cnt));
        check({name, "_illegal"}, 32'(illegal_count), 32'(exp_ill));
        exp_q.delete();
    endtask

    initial begin
        int n;
        int hs_at;
        int d;
        logic [ADDR_W-1:0] pc_h;

        vecs[0] = '{len: 1,  rnd: 1'b0, name: "len1",        exp_pc: 1};
        vecs[1] = '{len: 10, rnd: 1'b1, name: "len10_rnd",   exp_pc: 10};
        vecs[2] = '{len: 64, rnd: 1'b1, name: "len64_rnd",   exp_pc: 64};
        vecs[3] = '{len: 70, rnd: 1'b0, name: "len70_clamp", exp_pc: 64};
        vecs[4] = '{len: 5,  rnd: 1'b1, name: "len5_rnd",    exp_pc: 5};

        reset = 1'b1; load_we = 1'b0; load_addr = '0; load_data = '0;
        prog_len = '0; start = 1'b0; halt_req = 1'b0;
        fetch_bus.instr_ready = 1'b0;
        repeat (3) tick();
        reset = 1'b0;
        tick();
        check("rst_valid", 32'(fetch_bus.instr_valid), 32'd0);
        check("rst_instr", fetch_bus.instr, 32'd0);
        check("rst_pc", 32'(pc), 32'd0);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_done", 32'(done), 32'd0);
        check("rst_icount", 32'(instr_count), 32'd0);
        check("rst_illegal", 32'(illegal_count), 32'd0);

        for (int i = 0; i < PROG_DEPTH; i++) begin
            if (i == 0)      load_word(i, 32'h11, 1'b1);
            else if (i == 1) load_word(i, 32'h22, 1'b1);
            else if (i == 2) load_word(i, 32'h33, 1'b1);
            else             load_word(i, mk_word(i), 1'b1);
        end

        // Basic run with first-valid latency of three cycles after start
        fetch_bus.instr_ready = 1'b1;
        start_run(3);
        check("lat_n1_valid", 32'(fetch_bus.instr_valid), 32'd0);
        check("lat_n1_busy", 32'(busy), 32'd1);
        tick();
        check("lat_n2_valid", 32'(fetch_bus.instr_valid), 32'd0);
        tick();
`ifndef OPCODE_FILTER_EN
        check("lat_n3_valid", 32'(fetch_bus.instr_valid), 32'd1);
        check("lat_n3_instr", fetch_bus.instr, 32'h11);
`endif
        finish_run(1'b0, "basic");
        check("basic_pc", 32'(pc), 32'd3);

        // Backpressure: FIFO fills, pc stalls at FIFO_DEPTH, head held stable
        fetch_bus.instr_ready = 1'b0;
        start_run(10);
        repeat (12) tick();
`ifndef OPCODE_FILTER_EN
        check("bp_valid", 32'(fetch_bus.instr_valid), 32'd1);
        check("bp_instr", fetch_bus.instr, 32'h11);
        check("bp_pc", 32'(pc), 32'(FIFO_DEPTH));
`endif
        finish_run(1'b0, "bp");

        // Halt after five handshakes: nothing issued afterwards, drain completes
        fetch_bus.instr_ready = 1'b1;
        start_run(20);
        n = 0;
        while (hs_count < 5 && n < 200) begin tick(); n++; end
        check("halt_reach5", 32'(hs_count >= 5), 32'd1);
        hs_at = hs_count;
        halt_req = 1'b1;
        tick();
        halt_req = 1'b0;
        pc_h = pc;
        n = 0;
        while (!done && n < 200) begin tick(); n++; end
        d = hs_count;
        check("halt_done", 32'(done), 32'd1);
        check("halt_pc_frozen", 32'(pc), 32'(pc_h));
        check("halt_bound", 32'(d >= hs_at && d <= hs_at + FIFO_DEPTH), 32'd1);
        check("halt_truncated", 32'(d < exp_cnt), 32'd1);
        check("halt_icount", 32'(instr_count), 32'(d));
        exp_q.delete();

        // Zero-length program: straight to DONE, never valid
        valid_seen = 1'b0;
        start_run(0);
        check("len0_done", 32'(done), 32'd1);
        check("len0_busy", 32'(busy), 32'd0);
        repeat (5) tick();
        check("len0_novalid", 32'(valid_seen), 32'd0);
        check("len0_icount", 32'(instr_count), 32'd0);

        // Host write during RUN must not reach the program RAM
        start_run(10);
        tick();
        check("ldrun_busy", 32'(busy), 32'd1);
        load_word(0, 32'hDEADBEEF, 1'b0);
        finish_run(1'b0, "ldrun");

        // Restart from DONE: fresh run from pc 0, word 0 unchanged
        start_run(3);
        check("restart_pc", 32'(pc), 32'd0);
        check("restart_icount", 32'(instr_count), 32'd0);
        finish_run(1'b0, "restart");

        // Reset on the third handshake cycle aborts everything
        start_run(10);
        n = 0;
        while (hs_count < 2 && n < 100) begin tick(); n++; end
        reset = 1'b1;
        tick();
        reset = 1'b0;
        check("mrst_valid", 32'(fetch_bus.instr_valid), 32'd0);
        check("mrst_pc", 32'(pc), 32'd0);
        check("mrst_busy", 32'(busy), 32'd0);
        check("mrst_done", 32'(done), 32'd0);
        check("mrst_icount", 32'(instr_count), 32'd0);
        exp_q.delete();

        // Table of run configurations
        foreach (vecs[k]) begin
            start_run(vecs[k].len);
            finish_run(vecs[k].rnd, vecs[k].name);
            if (vecs[k].exp_pc < PROG_DEPTH)
                check({vecs[k].name, "_pc"}, 32'(pc), 32'(vecs[k].exp_pc));
        end

        // Program with an illegal word in the middle
        load_word(0, mk_word(40), 1'b1);
        load_word(1, 32'hFFFFFFFF, 1'b1);
        load_word(2, mk_word(41), 1'b1);
        start_run(3);
        finish_run(1'b0, "filter");

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached, required run to finish");
        $fatal(1);
    end

endmodule

// File: doc/calcore_fetch.md
Name: calcore_fetch

Overview:
- Instruction fetch stage directly upstream of the CalCore execute top; it supplies the 32-bit instruction word that the decoder consumes.
- Holds a host-loadable program RAM and a PC-driven fetch engine with one-cycle synchronous read.
- A small output FIFO delivers instructions over a valid/ready handshake, so execute-side backpressure never drops or duplicates a word.

Parameters:
- PROG_DEPTH, 64, number of 32-bit program words.
- ADDR_W, $clog2(PROG_DEPTH), PC and load-address width.
- FIFO_DEPTH, 4, output FIFO entries (power of 2, >=2).

Ports:
- clk  in  1  sole clock, rising edge.
- reset  in  1  synchronous, active-high.
- load_we  in  1  program write strobe; honoured only in IDLE/DONE.
- load_addr  in  ADDR_W  program write address.
- load_data  in  32  program word.
- prog_len  in  ADDR_W+1  instruction count; sampled on start; clamped to PROG_DEPTH.
- start  in  1  begin a run at PC 0.
- halt_req  in  1  stop fetching, drain what is already fetched.
- instr  out  32  instruction to decoder.
- instr_valid  out  1  instr is valid.
- instr_ready  in  1  downstream accepts this cycle.
- pc  out  ADDR_W  next address to be fetched.
- busy  out  1  state is RUN or DRAIN.
- done  out  1  state is DONE.
- instr_count  out  16  handshakes completed this run; saturates at 0xFFFF.
- illegal_count  out  8  words dropped by filter; saturating; tied 0 without the optional feature.

Behaviour:
- Reset values: state IDLE, pc 0, FIFO empty, instr 0, instr_valid 0, busy 0, done 0, instr_count 0, illegal_count 0. Program RAM contents are not reset.
- Reset asserted mid-run aborts immediately. In-flight reads are discarded and FIFO contents are lost.
- FSM states and transitions:
  - IDLE, on start: to RUN if latched length > 0, else to DONE. Latch length; clear pc and counters.
  - RUN: issue a read at pc and increment pc when fifo_count + inflight < FIFO_DEPTH. When pc == length after an issue, or halt_req=1, go to DRAIN. halt_req takes precedence over an issue in the same cycle; no read is issued.
  - DRAIN: no issues. When FIFO is empty and inflight = 0, go to DONE.
  - DONE: start is handled as in IDLE, then restarts.
  - start is ignored in RUN/DRAIN. halt_req is ignored outside RUN.
- Read latency: a RAM read issued in cycle k writes the FIFO at the end of cycle k+1. With start sampled in cycle N, instr_valid first rises in cycle N+3 (empty FIFO, instr_ready=1).
- FIFO and handshake:
  - A handshake completes on instr_valid & instr_ready; the entry is popped.
  - instr and instr_valid come from the registered FIFO head. instr is stable while valid and not ready.
  - Push and pop in the same cycle are allowed at any occupancy, including full. The credit rule prevents overflow.
  - Order strictly equals program order.
- Program RAM writes: load_we in IDLE/DONE writes at load_addr. In RUN/DRAIN it is ignored; no corruption of the active program.
- pc wraps never: the maximum value is the length, then it holds.

Optional Feature:
- OPCODE_FILTER_EN defined:
  - Each returned word is checked against the shared legal-instruction constants: opcode and funct3 must match set-height, set-weight, calc-BMI or calc-BMR.
  - Illegal words are not pushed, and illegal_count increments (saturating). Credit accounting treats the dropped word as released.
  - instr_count counts only delivered words.
- Undefined: every word is pushed unchanged; illegal_count is constant 0.

Decomposition:
- Shared package calcore_pkg:
  - Opcode/funct3 constants for the four instructions.
  - Fetch FSM state enum (IDLE, RUN, DRAIN, DONE).
  - INSTR_W = 32.
  - The decoder uses the same constants.
- One sub-module, calcore_fetch_fifo: synchronous FIFO with count output, simultaneous push/pop, registered head.

Test Plan:
- Basic run: load words 0x11,0x22,0x33, prog_len=3, start, ready=1 -> instr 0x11,0x22,0x33 on consecutive cycles starting N+3; done=1 after third handshake; instr_count=3.
- Backpressure: prog_len=10, ready=0 for 12 cycles -> FIFO holds 4, pc stops at 4, instr stays 0x11; release ready -> all 10 delivered in order, none duplicated.
- Halt: prog_len=20, halt_req pulsed after 5 handshakes -> no issue after halt cycle; the remaining FIFO/in-flight words are delivered; DONE; instr_count <= 5 + FIFO_DEPTH.
- Edge cases: prog_len=0 start -> DONE next cycle, instr_valid never high. load_we during RUN -> RAM unchanged (verify on rerun). start in DONE -> fresh run from pc 0 with instr_count reset.
- Reset mid-run at 3rd handshake -> next cycle instr_valid=0, pc=0, state IDLE, counters 0.
- OPCODE_FILTER_EN: program {legal, 0xFFFFFFFF, legal} -> two words delivered, illegal_count=1; without macro -> three delivered, illegal_count=0.
